// File: rtl/b10_vote_ctrl.sv
// b10 voting controller: ballot capture, red/green tally and coded result handshake.
// Optional self-test state is built only when B10_SELFTEST_EN is defined.
module b10_vote_ctrl #(
  parameter int BALLOTS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       key,
  input  logic       test,
  input  logic       r_button,
  input  logic       g_button,
  input  logic       rts,
  input  logic       rtr,
  input  logic [3:0] v_in,
  output logic       cts,
  output logic       ctr,
  output logic [3:0] v_out,
  output logic       busy
);

  localparam logic [3:0] LP_BALLOTS = 4'(BALLOTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RTS,
    S_CAPTURE,
    S_COLLECT,
    S_WAIT_RTR
`ifdef B10_SELFTEST_EN
    , S_TEST
`endif
  } state_t;

  state_t     r_state;
  logic [3:0] r_code;
  logic [3:0] r_red;
  logic [3:0] r_green;
  logic [3:0] r_nvotes;
  logic       r_cts;
  logic       r_ctr;
  logic [3:0] r_vout;
  logic       r_busy;

  logic       w_red_vote;
  logic       w_green_vote;
  logic [3:0] w_red_nx;
  logic [3:0] w_green_nx;
  logic [3:0] w_nvotes_nx;
  logic       w_close;
  logic [3:0] w_result;

`ifndef B10_SELFTEST_EN
  logic w_unused_test;
  assign w_unused_test = test;
`endif

  // Both buttons pressed together is an invalid vote and is not counted.
  assign w_red_vote   = r_button & ~g_button;
  assign w_green_vote = g_button & ~r_button;
  assign w_red_nx     = r_red    + {3'b000, w_red_vote};
  assign w_green_nx   = r_green  + {3'b000, w_green_vote};
  assign w_nvotes_nx  = r_nvotes + {3'b000, (w_red_vote | w_green_vote)};
  assign w_close      = (w_nvotes_nx == LP_BALLOTS);

  // Result uses the tallies including the closing vote.
  assign w_result = (w_red_nx > w_green_nx) ? r_code  :
                    (w_green_nx > w_red_nx) ? ~r_code : 4'b0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_code   <= 4'b0000;
      r_red    <= 4'b0000;
      r_green  <= 4'b0000;
      r_nvotes <= 4'b0000;
      r_cts    <= 1'b0;
      r_ctr    <= 1'b0;
      r_vout   <= 4'b0000;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_red    <= 4'b0000;
          r_green  <= 4'b0000;
          r_nvotes <= 4'b0000;
          r_cts    <= 1'b0;
          r_ctr    <= 1'b0;
          r_vout   <= 4'b0000;
          if (start) begin
            r_state <= S_WAIT_RTS;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_RTS: begin
`ifdef B10_SELFTEST_EN
          if (test) begin
            r_state <= S_TEST;
            r_vout  <= 4'b1010;
          end else
`endif
          if (rts && key) begin
            r_state <= S_CAPTURE;
            r_code  <= v_in;
            r_cts   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (!rts) begin
            r_state <= S_COLLECT;
            r_cts   <= 1'b0;
          end
        end
        S_COLLECT: begin
          // Dropping key abandons the ballot even if a vote arrives on the same edge.
          if (!key) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_red    <= w_red_nx;
            r_green  <= w_green_nx;
            r_nvotes <= w_nvotes_nx;
            if (w_close) begin
              r_state <= S_WAIT_RTR;
              r_ctr   <= 1'b1;
              r_vout  <= w_result;
            end
          end
        end
        S_WAIT_RTR: begin
          if (rtr) begin
            r_state <= S_IDLE;
            r_ctr   <= 1'b0;
            r_vout  <= 4'b0000;
            r_busy  <= 1'b0;
          end
        end
`ifdef B10_SELFTEST_EN
        S_TEST: begin
          if (!test) begin
            r_state <= S_IDLE;
            r_vout  <= 4'b0000;
            r_busy  <= 1'b0;
          end else begin
            r_vout <= ~r_vout;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_cts   <= 1'b0;
          r_ctr   <= 1'b0;
          r_vout  <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cts   = r_cts;
  assign ctr   = r_ctr;
  assign v_out = r_vout;
  assign busy  = r_busy;

endmodule
